// File: rtl/pretrig_capture_pkg.sv
// Shared types and helpers for the pre-trigger capture controller.
package pretrig_capture_pkg;

  typedef enum logic [2:0] {IDLE, ARMED, HEADER, DRAIN, POST} state_t;

  // Header beats carry all-ones sideband; sliced down to USER_W by the user.
  localparam int HDR_USER_MAX_W = 64;
  localparam logic [HDR_USER_MAX_W-1:0] HDR_USER = '1;

  function automatic int unsigned clamp_pre(input int unsigned len, input int unsigned depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/pretrig_capture_controller_ring.sv
// Pre-trigger history ring: write drops the oldest entry once fill reaches limit.
// Head and fill are combinational from state; clear empties it in one cycle.
module capture_ring_buffer #(
  parameter int W     = 40,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int FW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          wr,
  input  logic [W-1:0]  wr_dat,
  input  logic          pop,
  input  logic [FW-1:0] limit,
  output logic [W-1:0]  head,
  output logic [FW-1:0] fill
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          pop_ok, drop;

  assign pop_ok = pop && (fill != '0);
  assign drop   = wr && (fill >= limit) && !pop_ok;
  assign head   = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wptr <= '0;
      rptr <= '0;
      fill <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (pop_ok || drop) rptr <= rptr + 1'b1;
      if (wr && !drop && !pop_ok) fill <= fill + 1'b1;
      else if (pop_ok && !wr) fill <= fill - 1'b1;
    end
  end

endmodule

// File: rtl/pretrig_capture_controller.sv
// AXI-Stream capture: pre-trigger history then post-trigger passthrough, one frame per arm.
// CAPTURE_HEADER_EN adds a timestamp header beat ahead of the frame data.
module pretrig_capture_controller
  import pretrig_capture_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int USER_W    = 8,
  parameter int TS_W      = 32,
  parameter int PRE_DEPTH = 64,
  parameter int N_TRIG    = 4,
  localparam int SEL_W    = (N_TRIG > 1) ? $clog2(N_TRIG) : 1,
  localparam int PL_W     = $clog2(PRE_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [USER_W-1:0] s_tuser,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [USER_W-1:0] m_tuser,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  input  logic              arm,
  input  logic              abort,
  input  logic [N_TRIG-1:0] trigger_in,
  input  logic [SEL_W-1:0]  trig_sel,
  input  logic              trig_falling,
  input  logic [15:0]       debounce_cycles,
  input  logic [PL_W-1:0]   pre_length,
  input  logic [15:0]       post_length,
  input  logic [TS_W-1:0]   timestamp_counter,
  output logic [TS_W-1:0]   latched_timestamp,
  output logic              armed,
  output logic              capture_active,
  output logic              done
);

  state_t                     state, nstate;
  logic [N_TRIG-1:0]          sync_a, sync_q, sync_d;
  logic                       trig_edge, trig_valid;
  logic [15:0]                db_cnt, post_cnt, plen;
  logic [PL_W-1:0]            lim, fill;
  logic [DATA_W+USER_W-1:0]   head;
  logic                       ring_wr, ring_pop, ring_clear;
  logic                       qualify, finish, abort_pend;

  assign trig_edge  = trig_falling ? (sync_d[trig_sel] & ~sync_q[trig_sel])
                                   : (sync_q[trig_sel] & ~sync_d[trig_sel]);
  // A fresh edge overrides a countdown that happens to be expiring this cycle.
  assign trig_valid = trig_edge ? (debounce_cycles == 16'd0) : (db_cnt == 16'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_q <= '0;
      sync_d <= '0;
      db_cnt <= '0;
    end else begin
      sync_a <= trigger_in;
      sync_q <= sync_a;
      sync_d <= sync_q;
      if (trig_edge) db_cnt <= debounce_cycles;
      else if (db_cnt != 16'd0) db_cnt <= db_cnt - 16'd1;
    end
  end

  assign lim  = PL_W'(clamp_pre(32'(pre_length), PRE_DEPTH));
  assign plen = (post_length == 16'd0) ? 16'd1 : post_length;

  capture_ring_buffer #(.W(DATA_W + USER_W), .DEPTH(PRE_DEPTH)) u_ring (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (ring_clear),
    .wr     (ring_wr),
    .wr_dat ({s_tuser, s_tdata}),
    .pop    (ring_pop),
    .limit  (lim),
    .head   (head),
    .fill   (fill)
  );

  always_comb begin
    nstate     = state;
    s_tready   = 1'b0;
    m_tvalid   = 1'b0;
    m_tdata    = '0;
    m_tuser    = '0;
    m_tlast    = 1'b0;
    ring_wr    = 1'b0;
    ring_pop   = 1'b0;
    ring_clear = 1'b0;
    qualify    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (arm) begin
          nstate     = ARMED;
          ring_clear = 1'b1;
        end
      end
      ARMED: begin
        s_tready = 1'b1;
        ring_wr  = s_tvalid;
        if (abort) begin
          nstate     = IDLE;
          ring_clear = 1'b1;
        end else if (trig_valid && (fill == lim)) begin
          qualify = 1'b1;
`ifdef CAPTURE_HEADER_EN
          nstate = HEADER;
`else
          nstate = (lim != '0) ? DRAIN : POST;
`endif
        end
      end
`ifdef CAPTURE_HEADER_EN
      HEADER: begin
        m_tvalid = 1'b1;
        m_tdata  = DATA_W'(latched_timestamp);
        m_tuser  = HDR_USER[USER_W-1:0];
        m_tlast  = abort_pend;
        if (m_tready) begin
          if (abort_pend) finish = 1'b1;
          else nstate = (fill != '0) ? DRAIN : POST;
        end
      end
`endif
      DRAIN: begin
        m_tvalid = 1'b1;
        m_tdata  = head[DATA_W-1:0];
        m_tuser  = head[DATA_W+USER_W-1:DATA_W];
        m_tlast  = abort_pend;
        if (m_tready) begin
          ring_pop = 1'b1;
          if (abort_pend) finish = 1'b1;
          else if (fill == PL_W'(1)) nstate = POST;
        end
      end
      POST: begin
        s_tready = m_tready;
        m_tvalid = s_tvalid;
        m_tdata  = s_tdata;
        m_tuser  = s_tuser;
        m_tlast  = abort_pend || (post_cnt == plen - 16'd1);
        if (s_tvalid && m_tready && m_tlast) finish = 1'b1;
      end
      default: nstate = IDLE;
    endcase
    if (finish) nstate = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      latched_timestamp <= '0;
      done              <= 1'b0;
      abort_pend        <= 1'b0;
      post_cnt          <= '0;
    end else begin
      state <= nstate;
      done  <= finish;
      if (qualify) latched_timestamp <= timestamp_counter;
      // Abort in an output state only takes effect on the next completed beat.
      if (finish || state == IDLE) abort_pend <= 1'b0;
      else if (abort && state != ARMED) abort_pend <= 1'b1;
      if (state != POST) post_cnt <= '0;
      else if (s_tvalid && m_tready) post_cnt <= post_cnt + 16'd1;
    end
  end

  assign armed          = (state == ARMED);
  assign capture_active = (state == DRAIN) || (state == POST);

endmodule

// File: doc/pretrig_capture_controller.md
Name: pretrig_capture_controller

Overview:
- Next-generation AXI-Stream capture controller for the DAQ datapath.
- Adds a parametrised pre-trigger ring buffer, N selectable trigger inputs with edge polarity, explicit arm/abort control and frame completion status.
- Sits between the sample source stream and the DMA/packetiser stream; one frame per arm.
- Frame layout: pre-trigger history, then post-trigger samples, with m_tlast on the final beat.

Parameters:
- DATA_W, 32, sample width
- USER_W, 8, sideband width, stored with each buffered sample
- TS_W, 32, timestamp width
- PRE_DEPTH, 64, pre-trigger buffer depth; power of 2, at least 2
- N_TRIG, 4, number of trigger inputs; at least 1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- s_tdata/s_tuser/s_tvalid/s_tready  in/in/in/out  DATA_W/USER_W/1/1  input stream; s_tlast is not present
- m_tdata/m_tuser/m_tvalid/m_tready/m_tlast  out/out/out/in/out  DATA_W/USER_W/1/1/1  output stream
- arm  in  1  pulse: start a capture
- abort  in  1  pulse: cancel or terminate the capture
- trigger_in  in  N_TRIG  asynchronous trigger lines
- trig_sel  in  max(1,$clog2(N_TRIG))  trigger source select
- trig_falling  in  1  0 = rising edge, 1 = falling edge
- debounce_cycles  in  16  debounce delay
- pre_length  in  $clog2(PRE_DEPTH)+1  pre-trigger samples; values above PRE_DEPTH clamp to PRE_DEPTH
- post_length  in  16  post-trigger samples; 0 is treated as 1
- timestamp_counter  in  TS_W  free-running time
- latched_timestamp  out  TS_W  time of the qualified trigger
- armed  out  1  state == ARMED
- capture_active  out  1  state is DRAIN or POST
- done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset values: all outputs 0, state IDLE, ring buffer empty.
- Trigger path:
  - Each trigger_in bit passes through a 2-flop synchroniser.
  - Edge detect runs on the selected bit with the selected polarity.
  - An edge loads the debounce counter with debounce_cycles.
  - trig_valid asserts when the counter reaches 1, i.e. debounce_cycles cycles after the edge.
  - debounce_cycles == 0 gives trig_valid on the edge cycle.
  - A new edge during the countdown reloads the counter.
- IDLE:
  - s_tready = 0, m_tvalid = 0.
  - arm moves to ARMED and clears the buffer.
- ARMED:
  - s_tready = 1; every accepted beat is written to the ring.
  - fill count saturates at the clamped pre_length; once full, the oldest entry is overwritten.
  - trig_valid is honoured only when fill == pre_length; earlier triggers are ignored.
  - On a qualified trigger:
    - latched_timestamp <= timestamp_counter.
    - Next state is DRAIN if fill > 0, else POST.
  - A trigger and an input beat in the same cycle: the beat is buffered and becomes the newest pre-trigger sample.
- DRAIN:
  - s_tready = 0.
  - m_tvalid = 1 with the oldest buffered data and user.
  - Each m handshake pops one entry; after the last pop the state moves to POST.
  - m_tdata/m_tuser are stable while m_tvalid && !m_tready.
- POST:
  - Combinational passthrough: s_tready = m_tready, m_tvalid = s_tvalid.
  - A counter counts transfers.
  - m_tlast is asserted on transfer number post_length, counting the first as 1.
  - After that handshake: IDLE, done pulses for 1 cycle.
  - The counter is 16 bits; post_length 65535 is legal.
- abort handling:
  - In ARMED: go to IDLE immediately and clear the buffer; no done pulse.
  - In DRAIN/POST: set abort_pend. The next completed m handshake carries m_tlast = 1, then IDLE and done.
  - This never drops m_tvalid without a handshake.
- arm outside IDLE is ignored.
- Reset mid-frame returns to IDLE with an empty buffer; no tlast is emitted.
- Latency:
  - POST: 0 cycles.
  - First DRAIN beat is valid the cycle after the trigger is accepted.

Optional Feature:
- Macro: CAPTURE_HEADER_EN.
- When defined:
  - State HEADER is inserted after the trigger is accepted and before DRAIN/POST.
  - It emits one beat: m_tdata = latched_timestamp, zero-extended or truncated to DATA_W; m_tuser = all ones; m_tlast = 0.
  - HEADER counts toward neither length; s_tready = 0 in HEADER.
- When undefined: no HEADER state; the frame starts with the oldest pre-trigger sample.

Decomposition:
- Package pretrig_capture_pkg holds:
  - state_t enum: IDLE, ARMED, HEADER, DRAIN, POST.
  - HDR_USER constant.
  - clamp function for pre_length.
- Sub-module capture_ring_buffer (DATA_W+USER_W wide, PRE_DEPTH deep):
  - Ports: wr (overwrite-oldest when full), pop, clear.
  - Outputs: combinational head and fill count.

Test Plan:
- pre_length=4, post_length=3, debounce=2, continuous input 1,2,3…; rising edge on trig_sel=2 after 10 beats -> frame is the 4 newest pre-trigger beats plus the next 3, tlast on beat 7, done once, latched_timestamp = counter at trig_valid.
- Trigger edge after only 2 beats with pre_length=4 -> ignored, state stays ARMED; a later trigger is accepted.
- m_tready toggling 1/0 during DRAIN and POST -> data held stable while stalled, no beats lost or duplicated, s_tready=0 throughout DRAIN.
- abort during POST at beat 2 of post_length=10 -> next transfer has tlast, done pulses; abort in ARMED -> IDLE with no output.
- pre_length=0, post_length=0 -> single POST beat with tlast; trig_falling=1 responds only to falling edges; glitch shorter than debounce with re-edge restarts the count.
- With CAPTURE_HEADER_EN defined -> first beat carries the timestamp with tuser=8'hFF, followed by the pre- and post-trigger data unchanged.
